// File: rtl/y86_pkg.sv
// Shared Y86 constants, status codes and the instruction-memory load state.
package y86_pkg;

    // Instruction codes used by the memory server
    localparam logic [3:0] INOP = 4'h1;
    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [7:0] NOP_BYTE = {INOP, 4'h0};
    localparam logic [7:0] HALT_BYTE = {IHALT, 4'h0};

    // Longest Y86 instruction in bytes
    localparam int unsigned INSTR_MAX_BYTES = 10;

    // Pipeline status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Instruction memory load state
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } ld_state_e;

endpackage

// File: rtl/imem_window_rd.sv
// Combinational WIN-byte fetch window gather. Bytes at or beyond the
// loaded count read as halt (zero); the error flag compares the full PC.
module imem_window_rd #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 64,
    parameter int unsigned WIN   = 10
) (
    input  logic [7:0]              mem [DEPTH],
    input  logic [AW-1:0]           pc,
    input  logic [$clog2(DEPTH):0]  count,
    output logic [8*WIN-1:0]        instr_c,
    output logic                    error_c
);

    localparam int unsigned IW = $clog2(DEPTH);

    // Fetch address outside the loaded program
    assign error_c = (pc >= AW'(count));

    // One byte lane per window slot; AW+1 bits so pc+i never wraps to zero
    for (genvar i = 0; i < WIN; i++) begin : g_byte
        logic [AW:0] addr;
        assign addr = {1'b0, pc} + (AW+1)'(i);
        assign instr_c[8*(WIN-i)-1 -: 8] =
            (addr < (AW+1)'(count)) ? mem[addr[IW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/imem_server.sv
// Y86 instruction-memory server: accepts a program as a byte stream, then
// answers fetch requests with a registered WIN-byte window and error flag.
// Optional build macro IMEM_NOP_PREFIX_EN: address 0 always holds a nop and
// the program is loaded from address 1 onward.
module imem_server
    import y86_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 64,
    parameter int unsigned WIN   = INSTR_MAX_BYTES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    input  logic                    reload,
    input  logic                    fe_req,
    input  logic [AW-1:0]           fe_pc,
    output logic                    fe_valid,
    output logic [8*WIN-1:0]        fe_instr,
    output logic                    fe_error,
    output logic                    prog_loaded,
    output logic                    load_ovf,
    output logic [$clog2(DEPTH):0]  byte_count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
`ifdef IMEM_NOP_PREFIX_EN
    localparam logic [CW-1:0] WPTR_START = CW'(1);
`else
    localparam logic [CW-1:0] WPTR_START = CW'(0);
`endif
    localparam logic [CW-1:0] WPTR_FULL = CW'(DEPTH);

    ld_state_e          state;
    ld_state_e          state_d;
    logic [CW-1:0]      wptr;
    logic [CW-1:0]      wptr_d;
    logic               accept_c;
    logic               full_c;
    logic               ovf_d;
    logic               fe_take_c;
    logic [7:0]         mem    [DEPTH];
    logic [7:0]         mem_rd [DEPTH];
    logic [8*WIN-1:0]   win_instr_c;
    logic               win_error_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_d;
        end
    end

    // Next state: reload wins, then end of program or full array ends LOAD
    always_comb begin
        state_d = state;
        if (reload) begin
            state_d = LOAD;
        end else begin
            case (state)
                LOAD: if ((accept_c && ld_last) || full_c) state_d = RUN;
                RUN:  state_d = RUN;
                default: state_d = LOAD;
            endcase
        end
    end

    // Load/fetch control decode
    always_comb begin
        accept_c  = 1'b0;
        fe_take_c = 1'b0;
        wptr_d    = wptr;
        ovf_d     = load_ovf;
        full_c    = (wptr == WPTR_FULL);
        if (reload) begin
            wptr_d = WPTR_START;
            ovf_d  = 1'b0;
        end else if (state == LOAD) begin
            accept_c = ld_valid && ld_ready;
            if (accept_c) wptr_d = wptr + CW'(1);
            if (ld_valid && full_c) ovf_d = 1'b1;
        end else begin
            fe_take_c = fe_req;
        end
    end

    // Registered outputs and write pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= WPTR_START;
            ld_ready    <= 1'b1;
            prog_loaded <= 1'b0;
            load_ovf    <= 1'b0;
            fe_valid    <= 1'b0;
            fe_instr    <= '0;
            fe_error    <= 1'b0;
        end else begin
            wptr        <= wptr_d;
            ld_ready    <= (state_d == LOAD) && (wptr_d < WPTR_FULL);
            prog_loaded <= (state_d == RUN);
            load_ovf    <= ovf_d;
            fe_valid    <= fe_take_c;
            if (fe_take_c) begin
                fe_instr <= win_instr_c;
                fe_error <= win_error_c;
            end
        end
    end

    // Program byte storage; contents survive reset
    always_ff @(posedge clk) begin
        if (accept_c) mem[wptr[IW-1:0]] <= ld_data;
    end

    // Read view of the array; the nop prefix slot is never written by loads
    always_comb begin
        mem_rd = mem;
`ifdef IMEM_NOP_PREFIX_EN
        mem_rd[0] = NOP_BYTE;
`endif
    end

    assign byte_count = wptr;

    imem_window_rd #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIN   (WIN)
    ) u_window_rd (
        .mem     (mem_rd),
        .pc      (fe_pc),
        .count   (wptr),
        .instr_c (win_instr_c),
        .error_c (win_error_c)
    );

endmodule

// File: tb/tb_imem_server.sv
// Bench for imem_server: table of fetch vectors plus hand-written load,
// reload, overflow and asynchronous-reset sequences, with a response queue.
module tb_imem_server;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 64;
    localparam int unsigned WIN   = 10;
    localparam int unsigned CW    = 9;
`ifdef IMEM_NOP_PREFIX_EN
    localparam int unsigned START = 1;
`else
    localparam int unsigned START = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            ld_valid;
    logic [7:0]      ld_data;
    logic            ld_last;
    logic            ld_ready;
    logic            reload;
    logic            fe_req;
    logic [AW-1:0]   fe_pc;
    logic            fe_valid;
    logic [8*WIN-1:0] fe_instr;
    logic            fe_error;
    logic            prog_loaded;
    logic            load_ovf;
    logic [CW-1:0]   byte_count;

    imem_server #(.DEPTH(DEPTH), .AW(AW), .WIN(WIN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .reload      (reload),
        .fe_req      (fe_req),
        .fe_pc       (fe_pc),
        .fe_valid    (fe_valid),
        .fe_instr    (fe_instr),
        .fe_error    (fe_error),
        .prog_loaded (prog_loaded),
        .load_ovf    (load_ovf),
        .byte_count  (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] instr;
        logic        err;
    } resp_t;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] instr;
        logic        err;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    resp_t       sbq[$];
    bit          want_v = 1'b0;
    vec_t        vecs[8];
    logic [7:0]  prog[$];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock; checks fe_valid every cycle and pops the queue on a response
    task automatic tick();
        bit w;
        resp_t r;
        w = want_v;
        want_v = 1'b0;
        @(posedge clk);
        #1;
        chk("fe_valid", 80'(fe_valid), 80'(w));
        if (fe_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fe_unexpected: got response with empty queue");
            end else begin
                r = sbq.pop_front();
                chk("fe_instr", 80'(fe_instr), r.instr);
                chk("fe_error", 80'(fe_error), 80'(r.err));
            end
        end
    endtask

    task automatic fetch(input logic [63:0] pc, input logic [79:0] ei, input logic ee);
        resp_t r;
        r.instr = ei;
        r.err   = ee;
        fe_req = 1'b1;
        fe_pc  = pc;
        sbq.push_back(r);
        want_v = 1'b1;
        tick();
        fe_req = 1'b0;
    endtask

    task automatic fetch_drop(input logic [63:0] pc);
        fe_req = 1'b1;
        fe_pc  = pc;
        tick();
        fe_req = 1'b0;
    endtask

    task automatic load(input logic [7:0] b[$], input bit last);
        int n;
        for (int i = 0; i < b.size(); i++) begin
            ld_valid = 1'b1;
            ld_data  = b[i];
            ld_last  = last && (i == b.size() - 1);
            n = 0;
            while (!ld_ready && n < 20) begin
                tick();
                n++;
            end
            if (!ld_ready) begin
                total++;
                bad++;
                $display("FAIL ld_ready_timeout: got 0 expected 1 at byte %0d", i);
            end
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ld_ready"},    80'(ld_ready),    80'(1));
        chk({tag, "_fe_valid"},    80'(fe_valid),    80'(0));
        chk({tag, "_fe_instr"},    80'(fe_instr),    80'(0));
        chk({tag, "_fe_error"},    80'(fe_error),    80'(0));
        chk({tag, "_prog_loaded"}, 80'(prog_loaded), 80'(0));
        chk({tag, "_load_ovf"},    80'(load_ovf),    80'(0));
        chk({tag, "_byte_count"},  80'(byte_count),  80'(START));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [79:0] ew;
        int          a;

        rst_n = 1'b0; ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
        reload = 1'b0; fe_req = 1'b0; fe_pc = '0;

`ifdef IMEM_NOP_PREFIX_EN
        vecs[0] = '{64'd0, 80'h1030F20A000000000000, 1'b0};
        vecs[1] = '{64'd1, 80'h30F20A00000000000000, 1'b0};
        vecs[2] = '{64'd3, 80'h0A000000000000000000, 1'b0};
        vecs[3] = '{64'd4, 80'h0, 1'b0};
        vecs[4] = '{64'd6, 80'h0, 1'b1};
        vecs[5] = '{64'h1_0000_0000, 80'h0, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h0, 1'b1};
        vecs[7] = '{64'd5, 80'h0, 1'b0};
`else
        vecs[0] = '{64'd0, 80'h30F20A00000000000000, 1'b0};
        vecs[1] = '{64'd1, 80'hF20A0000000000000000, 1'b0};
        vecs[2] = '{64'd3, 80'h0, 1'b0};
        vecs[3] = '{64'd4, 80'h0, 1'b0};
        vecs[4] = '{64'd5, 80'h0, 1'b1};
        vecs[5] = '{64'h1_0000_0000, 80'h0, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 80'h0, 1'b1};
        vecs[7] = '{64'd2, 80'h0A000000000000000000, 1'b0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Fetch during LOAD is ignored
        fetch_drop(64'd0);

        // Five-byte program, then the fetch vector table
        prog = {8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00};
        load(prog, 1'b1);
        chk("byte_count_5", 80'(byte_count), 80'(5 + START));
        chk("prog_loaded_5", 80'(prog_loaded), 80'(1));
        chk("ld_ready_run", 80'(ld_ready), 80'(0));
        for (int i = 0; i < 8; i++) begin
            fetch(vecs[i].pc, vecs[i].instr, vecs[i].err);
        end
        tick();
        chk("fe_instr_hold", 80'(fe_instr), vecs[7].instr);

        // Reload mid-RUN with a simultaneous fetch that must be dropped
        fe_req = 1'b1; fe_pc = 64'd0; reload = 1'b1;
        tick();
        reload = 1'b0; fe_req = 1'b0;
        chk("reload_prog_loaded", 80'(prog_loaded), 80'(0));
        chk("reload_byte_count", 80'(byte_count), 80'(START));
        chk("reload_ld_ready", 80'(ld_ready), 80'(1));
        prog = {8'h10, 8'h00};
        load(prog, 1'b1);
`ifdef IMEM_NOP_PREFIX_EN
        fetch(64'd0, 80'h10100000000000000000, 1'b0);
`else
        fetch(64'd0, 80'h10000000000000000000, 1'b0);
`endif
        chk("byte_count_2", 80'(byte_count), 80'(2 + START));

        // Stream past capacity without ld_last
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < int'(DEPTH - START); i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            ld_last  = 1'b0;
            tick();
        end
        chk("full_ld_ready", 80'(ld_ready), 80'(0));
        chk("full_ovf_pre", 80'(load_ovf), 80'(0));
        chk("full_still_load", 80'(prog_loaded), 80'(0));
        ld_data = 8'hEE;
        tick();
        ld_valid = 1'b0;
        chk("ovf_load_ovf", 80'(load_ovf), 80'(1));
        chk("ovf_prog_loaded", 80'(prog_loaded), 80'(1));
        chk("ovf_byte_count", 80'(byte_count), 80'(DEPTH));
        chk("ovf_ld_ready", 80'(ld_ready), 80'(0));
        fetch(64'(DEPTH), 80'h0, 1'b1);
        ew = '0;
        for (int k = 0; k < int'(WIN); k++) begin
            a = int'(DEPTH) - 4 + k;
            ew[8*(int'(WIN)-k)-1 -: 8] = (a < int'(DEPTH)) ? 8'(a - int'(START)) : 8'h00;
        end
        fetch(64'(DEPTH - 4), ew, 1'b0);

        // Asynchronous reset in the middle of a load
        reload = 1'b1;
        tick();
        reload = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(8'hA0 + i);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        prog = {8'h60, 8'h23, 8'h70, 8'h11, 8'h22, 8'h33};
        load(prog, 1'b1);
        chk("reload6_byte_count", 80'(byte_count), 80'(6 + START));
`ifdef IMEM_NOP_PREFIX_EN
        fetch(64'd0, 80'h10602370112233000000, 1'b0);
`else
        fetch(64'd0, 80'h60237011223300000000, 1'b0);
`endif
        fetch(64'(6 + START), 80'h0, 1'b1);
        tick();
        chk("sb_empty", 80'(sbq.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
